// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM states and the
// funct-to-op mapping used by the EX decoder.
package md_pkg;

    localparam int unsigned MD_OP_W = 3;

    // Unit op encodings
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd7;

    // R-type funct fields that map onto unit ops
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Decoder helper: funct field to unit op (MD_NONE when not a unit op)
    function automatic logic [MD_OP_W-1:0] funct_to_op(input logic [5:0] funct);
        logic [MD_OP_W-1:0] res;
        res = MD_NONE;
        case (funct)
            FUNCT_MTHI:  res = MD_MTHI;
            FUNCT_MTLO:  res = MD_MTLO;
            FUNCT_MULT:  res = MD_MULT;
            FUNCT_MULTU: res = MD_MULTU;
            FUNCT_DIV:   res = MD_DIV;
            FUNCT_DIVU:  res = MD_DIVU;
            default:     res = MD_NONE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling for the multiply/divide unit.
// Ports:
//   a, b            raw operands;  is_signed selects two's complement view
//   abs_a_c/abs_b_c operand magnitudes; sign_a_c/sign_b_c operand signs
//   acc             unsigned magnitude result {hi,lo} from the iterative core
//   is_mul          1: acc is a product, 0: acc is {remainder, quotient}
//   res_sign_a/b    operand signs latched at op start
//   fixed_c         sign-corrected {hi,lo}
module md_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic [WIDTH-1:0]   abs_a_c,
    output logic [WIDTH-1:0]   abs_b_c,
    output logic               sign_a_c,
    output logic               sign_b_c,
    input  logic [2*WIDTH-1:0] acc,
    input  logic               is_mul,
    input  logic               res_sign_a,
    input  logic               res_sign_b,
    output logic [2*WIDTH-1:0] fixed_c
);

    // Operand magnitudes on entry
    always_comb begin
        sign_a_c = is_signed & a[WIDTH-1];
        sign_b_c = is_signed & b[WIDTH-1];
        abs_a_c  = sign_a_c ? (~a + WIDTH'(1)) : a;
        abs_b_c  = sign_b_c ? (~b + WIDTH'(1)) : b;
    end

    // Result negation: product by sign xor; quotient by sign xor, remainder by dividend sign
    always_comb begin
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
        rem     = acc[2*WIDTH-1:WIDTH];
        quo     = acc[WIDTH-1:0];
        fixed_c = acc;
        if (is_mul) begin
            if (res_sign_a ^ res_sign_b) begin
                fixed_c = ~acc + (2*WIDTH)'(1);
            end
        end else begin
            if (res_sign_a ^ res_sign_b) begin
                quo = ~quo + WIDTH'(1);
            end
            if (res_sign_a) begin
                rem = ~rem + WIDTH'(1);
            end
            fixed_c = {rem, quo};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Ports:
//   CLK, RST        clock; synchronous active-low reset
//   start, op       request and op code (sampled only while busy=0)
//   rs, rt          operand A (multiplicand/dividend/MTHI-MTLO data), operand B
//   flush           abort the in-flight op, HI/LO unchanged
//   busy            op in flight
//   done            one-cycle pulse when HI/LO take a MULT/DIV result
//   div_by_zero     one-cycle pulse with done for a zero divisor
//   hi, lo          HI/LO registers
module ex_muldiv_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_mul_q, is_mul_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   abs_a_c, abs_b_c;
    logic               sign_a_c, sign_b_c;
    logic [ACC_W-1:0]   fixed_c;
    logic               is_signed_c;

    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     rem_sh_c;
    logic [WIDTH-1:0]   rem_diff_c;
    logic               rem_ge_c;

    assign is_signed_c = (op == MD_MULT) || (op == MD_DIV);

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a          (rs),
        .b          (rt),
        .is_signed  (is_signed_c),
        .abs_a_c    (abs_a_c),
        .abs_b_c    (abs_b_c),
        .sign_a_c   (sign_a_c),
        .sign_b_c   (sign_b_c),
        .acc        (acc_q),
        .is_mul     (is_mul_q),
        .res_sign_a (sign_a_q),
        .res_sign_b (sign_b_q),
        .fixed_c    (fixed_c)
    );

    // Datapath step: shift-add on the upper half, or restoring subtract of the shifted remainder
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, opb_q};
        rem_sh_c   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge_c   = rem_sh_c >= {1'b0, opb_q};
        // Only consumed when rem_ge_c, where the true difference fits in WIDTH bits
        rem_diff_c = rem_sh_c[WIDTH-1:0] - opb_q;
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_mul_d = is_mul_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start && !flush) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            // Low half holds the multiplier, shifted out LSB first
                            acc_d    = {WIDTH'(0), abs_b_c};
                            opb_d    = abs_a_c;
                            is_mul_d = 1'b1;
                            sign_a_d = sign_a_c;
                            sign_b_d = sign_b_c;
                            dz_d     = 1'b0;
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            // Low half holds the dividend, shifted out MSB first
                            acc_d    = {WIDTH'(0), abs_a_c};
                            opb_d    = abs_b_c;
                            is_mul_d = 1'b0;
                            sign_a_d = sign_a_c;
                            sign_b_d = sign_b_c;
                            dz_d     = (rt == '0);
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = ST_RUN;
                        end
                        MD_MTHI: hi_d = rs;
                        MD_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end

            ST_RUN: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (is_mul_q) begin
                        acc_d = acc_q[0] ? {mul_sum_c, acc_q[WIDTH-1:1]}
                                         : {1'b0, acc_q[ACC_W-1:1]};
                    end else begin
                        acc_d = rem_ge_c ? {rem_diff_c, acc_q[WIDTH-2:0], 1'b1}
                                         : {rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (!flush) begin
                    // Zero divisor: remainder correction restores raw rs; quotient forced to all ones
                    hi_d   = fixed_c[ACC_W-1:WIDTH];
                    lo_d   = dz_q ? '1 : fixed_c[WIDTH-1:0];
                    done_d = 1'b1;
                    dbz_d  = dz_q;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_mul_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_mul_q <= is_mul_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit (WIDTH=32): the driver pushes the
// expected HI/LO/flag and due cycle for every accepted MULT/DIV; a monitor
// pops and compares on each done pulse.
module tb_ex_muldiv_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = MD_MULTU;
    logic [W-1:0]  rs = '0;
    logic [W-1:0]  rt = '0;
    logic          flush = 1'b0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .rs(rs), .rt(rt),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the arithmetic rules
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [63:0] p;
        int sa, sb_i;
        e.dbz = 1'b0;
        e.due = 0;
        e.hi = '0;
        e.lo = '0;
        case (o)
            MD_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = p;
            end
            MD_MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                {e.hi, e.lo} = p;
            end
            default: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dbz = 1'b1;
                end else if (o == MD_DIVU) begin
                    e.lo = a / b; e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = a; e.hi = '0;
                end else begin
                    sa = $signed(a); sb_i = $signed(b);
                    e.lo = 32'(sa / sb_i); e.hi = 32'(sa % sb_i);
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done must match the oldest expected result, on time
    always @(negedge CLK) begin
        if (RST && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_hi", 64'(hi), 64'(e.hi));
                chk("res_lo", 64'(lo), 64'(e.lo));
                chk("res_dbz", 64'(div_by_zero), 64'(e.dbz));
                chk("res_latency", 64'(cyc), 64'(e.due));
                chk("busy_at_done", 64'(busy), 64'(0));
            end
        end else if (RST && div_by_zero) begin
            chk("dbz_without_done", 64'(div_by_zero), 64'(0));
        end
        if (sb.size() != 0 && cyc > sb[0].due) begin
            chk("done_timeout", 64'(cyc), 64'(sb[0].due));
            void'(sb.pop_front());
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    // Issue one op at a negedge; tracked MULT/DIV ops go to the scoreboard
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
        exp_t e;
        wait_idle();
        start = 1'b1; op = o; rs = a; rt = b;
        if (o == MD_MTHI) mdl_hi = a;
        else if (o == MD_MTLO) mdl_lo = a;
        else if (track) begin
            e = model(o, a, b);
            // Sampling edge is cyc+1; result shows after WIDTH+1 further edges
            e.due = cyc + W + 2;
            sb.push_back(e);
            mdl_hi = e.hi;
            mdl_lo = e.lo;
        end
        @(negedge CLK);
        start = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'(($urandom_range(0, 15)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0] ops [4];
        int d0;
        ops[0] = MD_MULT; ops[1] = MD_MULTU; ops[2] = MD_DIV; ops[3] = MD_DIVU;

        repeat (3) @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        RST = 1'b1;
        @(negedge CLK);

        // Directed cases
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b1);
        issue(MD_MULT,  32'hFFFF_FFFD, 32'h7, 1'b1);
        issue(MD_DIV,   32'hFFFF_FFF9, 32'h2, 1'b1);
        issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(MD_DIVU,  32'h1234_5678, 32'h0, 1'b1);
        issue(MD_DIV,   32'hFFFF_FF00, 32'h0, 1'b1);

        // MTLO: visible next edge, busy stays low
        issue(MD_MTLO, 32'hDEAD_BEEF, 32'h0, 1'b0);
        chk("mtlo_lo", 64'(lo), 64'(32'hDEAD_BEEF));
        chk("mtlo_busy", 64'(busy), 64'(0));
        issue(MD_MTHI, 32'hCAFE_F00D, 32'h0, 1'b0);
        chk("mthi_hi", 64'(hi), 64'(32'hCAFE_F00D));
        chk("mthi_done", 64'(done), 64'(0));

        // Flush mid-RUN with a concurrent start that must be ignored
        issue(MD_MULTU, 32'h0001_0001, 32'h0003_0003, 1'b0);
        repeat (9) @(negedge CLK);
        start = 1'b1; op = MD_MTHI; rs = 32'h1111_1111; flush = 1'b1;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_hi", 64'(hi), 64'(mdl_hi));
        chk("flush_lo", 64'(lo), 64'(mdl_lo));
        repeat (40) @(negedge CLK);

        // Flush during the FIX cycle
        d0 = cyc;
        issue(MD_DIVU, 32'h0000_0064, 32'h0000_0007, 1'b0);
        while (cyc < d0 + W + 1) @(negedge CLK);
        chk("fix_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        chk("fixflush_busy", 64'(busy), 64'(0));
        chk("fixflush_hi", 64'(hi), 64'(mdl_hi));
        chk("fixflush_lo", 64'(lo), 64'(mdl_lo));

        // Flush and start together while idle: op dropped
        start = 1'b1; op = MD_MTLO; rs = 32'h5555_AAAA; flush = 1'b1;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        chk("idleflush_lo", 64'(lo), 64'(mdl_lo));
        chk("idleflush_busy", 64'(busy), 64'(0));

        // Randomized ops, back-to-back, with ignored starts while busy
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                issue($urandom_range(0, 1) == 0 ? MD_MTHI : MD_MTLO, $urandom, 32'h0, 1'b0);
                chk("rnd_mt", 64'({hi, lo}), 64'({mdl_hi, mdl_lo}));
            end else begin
                issue(ops[$urandom_range(0, 3)], rnd_operand(), rnd_operand(), 1'b1);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 20)) @(negedge CLK);
                    start = 1'b1; op = ops[$urandom_range(0, 3)]; rs = $urandom; rt = $urandom;
                    @(negedge CLK);
                    start = 1'b0;
                end
            end
        end
        wait_idle();
        repeat (2) @(negedge CLK);

        // Reset mid-RUN clears everything
        issue(MD_MULT, 32'h0000_1234, 32'hFFFF_0001, 1'b0);
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_hi", 64'(hi), 64'(0));
        chk("midrst_lo", 64'(lo), 64'(0));
        RST = 1'b1;
        repeat (40) @(negedge CLK);
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
